multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle RV32I-subset datapath.
- Sequences the datapath through fetch, decode, execute, memory and writeback.
- Drives the 2-bit alu_op consumed by the ALU control decoder, plus all mux selects and write enables.
- Handshakes with a shared instruction/data memory that can stall.

---
 rtl/multicycle_control_pkg.sv | 50 +++++
 rtl/multicycle_control_if.sv | 31 +++
 rtl/multicycle_control.sv | 118 +++++++++++
 tb/tb_multicycle_control.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared states, opcodes and select encodings for the multi-cycle RV32I control path
package multicycle_control_pkg;
  localparam int OPCODE_W = 7;
  localparam int STATE_W = 4;
  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd10
  } state_t;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal_instr;
  } ctrl_t;
  function automatic logic is_supported(input logic [OPCODE_W-1:0] op);
    return op == OP_LOAD || op == OP_STORE || op == OP_RTYPE || op == OP_ITYPE || op == OP_BRANCH;
  endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control bundle between the multi-cycle controller (master) and its datapath/memory (slave)
interface multicycle_control_if
  import multicycle_control_pkg::*;
;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                mem_read;
  logic                mem_write;
  logic                i_or_d;
  logic                ir_write;
  logic                pc_write;
  logic                pc_write_cond;
  logic                pc_source;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                reg_write;
  logic                mem_to_reg;
  logic                illegal_instr;
  logic [STATE_W-1:0]  state_o;
  modport master (
    input  opcode, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal_instr, state_o
  );
  modport slave (
    output opcode, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal_instr, state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/memory/writeback sequencer for the multi-cycle RV32I datapath.
// Define MULTICYCLE_CONTROL_TRAP_EN to make unsupported opcodes lock into TRAP until reset.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input logic clk,
  input logic rst_n,
  multicycle_control_if.master bus
);
`ifdef MULTICYCLE_CONTROL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = TRAP;
`else
  localparam state_t ILLEGAL_NEXT = FETCH;
`endif
  state_t state, state_next;
  ctrl_t ctrl, ctrl_out;
  logic is_load, is_store;
  assign is_load = bus.opcode == OP_LOAD;
  assign is_store = bus.opcode == OP_STORE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= state_next;
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:    state_next = bus.mem_ready ? DECODE : FETCH;
      DECODE:   state_next = (is_load || is_store) ? MEM_ADDR :
                             bus.opcode == OP_RTYPE  ? EXEC_R :
                             bus.opcode == OP_ITYPE  ? EXEC_I :
                             bus.opcode == OP_BRANCH ? BRANCH : ILLEGAL_NEXT;
      MEM_ADDR: state_next = is_load ? MEM_RD : is_store ? MEM_WR : FETCH;
      MEM_RD:   state_next = bus.mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   state_next = bus.mem_ready ? FETCH : MEM_WR;
      EXEC_R:   state_next = ALU_WB;
      EXEC_I:   state_next = ALU_WB;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
      TRAP:     state_next = TRAP;
`endif
      default:  state_next = FETCH;
    endcase
  end
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op = ALUOP_ADD;
        ctrl.ir_write = bus.mem_ready;
        ctrl.pc_write = bus.mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op = ALUOP_ADD;
`ifndef MULTICYCLE_CONTROL_TRAP_EN
        ctrl.illegal_instr = !is_supported(bus.opcode);
`endif
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op = ALUOP_ADD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d = 1'b1;
      end
      EXEC_R: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op = ALUOP_FUNCT;
      end
      EXEC_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op = ALUOP_FUNCT;
      end
      ALU_WB: ctrl.reg_write = 1'b1;
      BRANCH: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
      TRAP: ctrl.illegal_instr = 1'b1;
`endif
      default: ctrl = '0;
    endcase
  end
  // Gating by rst_n kills any in-flight request the instant reset asserts.
  assign ctrl_out = rst_n ? ctrl : '0;
  assign bus.mem_read = ctrl_out.mem_read;
  assign bus.mem_write = ctrl_out.mem_write;
  assign bus.i_or_d = ctrl_out.i_or_d;
  assign bus.ir_write = ctrl_out.ir_write;
  assign bus.pc_write = ctrl_out.pc_write;
  assign bus.pc_write_cond = ctrl_out.pc_write_cond;
  assign bus.pc_source = ctrl_out.pc_source;
  assign bus.alu_src_a = ctrl_out.alu_src_a;
  assign bus.alu_src_b = ctrl_out.alu_src_b;
  assign bus.alu_op = ctrl_out.alu_op;
  assign bus.reg_write = ctrl_out.reg_write;
  assign bus.mem_to_reg = ctrl_out.mem_to_reg;
  assign bus.illegal_instr = ctrl_out.illegal_instr;
  assign bus.state_o = state;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle trace model of each instruction class checked against the controller
module tb_multicycle_control;
  localparam logic [6:0] OL = 7'b0000011, OS = 7'b0100011, OR = 7'b0110011, OI = 7'b0010011, OB = 7'b1100011;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif
  typedef struct {
    logic        rdy;
    logic [6:0]  op;
    logic [3:0]  st;
    logic [15:0] ctl;
  } step_t;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  step_t q[$];
  multicycle_control_if bus();
  multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] ctl_now();
    return {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write, bus.pc_write_cond,
            bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.mem_to_reg,
            bus.illegal_instr};
  endfunction
  function automatic bit legal(input logic [6:0] op);
    return op == OL || op == OS || op == OR || op == OI || op == OB;
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic add(input logic rdy, input logic [6:0] op, input int st,
                     input logic mr, input logic mw, input logic iod, input logic irw, input logic pcw,
                     input logic pcc, input logic pcs, input logic [1:0] sa, input logic [1:0] sb,
                     input logic [1:0] aop, input logic rw, input logic m2r, input logic ill);
    step_t s;
    s.rdy = rdy;
    s.op = op;
    s.st = 4'(st);
    s.ctl = {mr, mw, iod, irw, pcw, pcc, pcs, sa, sb, aop, rw, m2r, ill};
    q.push_back(s);
  endtask
  // One expected cycle per queue entry: fw fetch stalls, mw data-memory stalls.
  task automatic plan(input logic [6:0] op, input int fw, input int mw);
    logic r;
    for (int i = 0; i <= fw; i++) begin
      r = (i == fw);
      add(r, 7'($urandom), 0, 1, 0, 0, r, r, 0, 0, 2'd0, 2'd1, 2'd0, 0, 0, 0);
    end
    add(1'($urandom), op, 1, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 2'd0, 0, 0, !legal(op) && !TRAP_ON);
    if (op == OL || op == OS) add(1'($urandom), op, 2, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 0, 0, 0);
    if (op == OL) begin
      for (int i = 0; i <= mw; i++) add(i == mw, op, 3, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
      add(1'($urandom), op, 4, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 1, 0);
    end
    if (op == OS)
      for (int i = 0; i <= mw; i++) add(i == mw, op, 5, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    if (op == OR || op == OI) begin
      add(1'($urandom), op, op == OR ? 6 : 7, 0, 0, 0, 0, 0, 0, 0, 2'd1, op == OR ? 2'd0 : 2'd2, 2'd2, 0, 0, 0);
      add(1'($urandom), op, 8, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 0, 0);
    end
    if (op == OB) add(1'($urandom), op, 9, 0, 0, 0, 0, 0, 1, 1, 2'd1, 2'd0, 2'd1, 0, 0, 0);
    if (!legal(op) && TRAP_ON)
      for (int i = 0; i < 20; i++) add(1'($urandom), 7'($urandom), 10, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 1);
  endtask
  task automatic run_steps(input int n);
    step_t s;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      s = q.pop_front();
      @(negedge clk);
      bus.mem_ready = s.rdy;
      bus.opcode = s.op;
      #4;
      chk($sformatf("state(exp %0d)", s.st), 16'(bus.state_o), 16'(s.st));
      chk($sformatf("ctl(st %0d)", s.st), ctl_now(), s.ctl);
      chk("rd_wr_exclusive", 16'(bus.mem_read & bus.mem_write), 16'd0);
    end
  endtask
  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_state", 16'(bus.state_o), 16'd0);
    chk("rst_ctl", ctl_now(), 16'd0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic do_instr(input logic [6:0] op, input int fw, input int mw);
    plan(op, fw, mw);
    run_steps(1000);
    if (TRAP_ON && !legal(op)) reset_pulse();
  endtask
  initial begin
    logic [6:0] rop;
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = OS;
    #3;
    chk("reset_state", 16'(bus.state_o), 16'd0);
    chk("reset_ctl", ctl_now(), 16'd0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    do_instr(OR, 0, 0);
    do_instr(OL, 0, 3);
    do_instr(OS, 2, 0);
    do_instr(OB, 0, 0);
    do_instr(7'b1111111, 0, 0);
    do_instr(OI, 1, 0);
    plan(OS, 0, 3);
    run_steps(4);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #2;
    chk("midwr_state", 16'(bus.state_o), 16'd5);
    chk("midwr_write", 16'(bus.mem_write), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_state", 16'(bus.state_o), 16'd0);
    chk("abort_ctl", ctl_now(), 16'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom % 6)
        0: rop = OL;
        1: rop = OS;
        2: rop = OR;
        3: rop = OI;
        4: rop = OB;
        default: rop = 7'($urandom);
      endcase
      do_instr(rop, int'($urandom % 3), int'($urandom % 4));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
